seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle ALU.
- Adds EOR, BIC and an iterative shift-add MUL, with a start/busy/done handshake.
- Sits between the multicycle controller and the datapath register stage.
- Controller pulses start, waits for done, then samples result and flags; the flags are gated by FlagW externally.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
CNTW, $clog2(WIDTH+1), width of multiply iteration counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 BIC (a & ~b), 111 reserved
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
result  output  WIDTH  registered result; holds until next done
flags  output  4  {N,Z,C,V}, registered together with result
busy  output  1  high while a MUL is in progress
done  output  1  one-cycle pulse, coincident with new result/flags

Behaviour:
- Reset (async): state=IDLE; result=0, flags=0, busy=0, done=0; accumulator, multiplicand, multiplier and counter cleared. Reset mid-MUL aborts with no done.
- States: IDLE, MULT.
- IDLE, start=1, op!=MUL, at edge k:
  - result/flags written; done=1 for cycle k..k+1; stays IDLE.
  - Latency 1.
- IDLE, start=1, op=MUL, at edge k:
  - acc=0, mcand=a, mplier=b, cnt=0; busy=1; go to MULT.
- MULT, each edge:
  - if mplier[0], acc += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; cnt++.
  - At the edge where cnt reaches WIDTH: result = final acc, flags written, done=1, busy=0, go to IDLE.
  - Latency WIDTH cycles: done visible after edge k+WIDTH.
- start while busy is ignored. Operands are not re-sampled; a/b may change freely during MULT.
- start in the cycle done is high is accepted (state is already IDLE): back-to-back operation.
- ADD: {C,sum} = a + b.
- SUB: {C,sum} = a + ~b + 1, so C=1 means no borrow.
- V (ADD/SUB): operands' effective signs equal and sum sign differs.
- AND/ORR/EOR/BIC/MUL: C=0, V=0.
- MUL result is the low WIDTH bits of a*b (unsigned; identical for two's complement low half).
- N = result[WIDTH-1]; Z = (result == 0), for all ops.
- op=111: result=0, flags=0100, done after 1 cycle, like any non-MUL op.
- done is never high two consecutive cycles unless back-to-back starts are issued.

Optional Feature:
- Macro: SEQ_ALU_EARLY_TERM_EN.
- Defined: MUL finishes at the first edge where the post-shift mplier == 0, or cnt reaches WIDTH, whichever comes first.
  - Latency = max(1, index of highest set bit of b + 1) cycles.
  - b=0 gives done after 1 cycle with result 0.
- Undefined: fixed WIDTH-cycle MUL regardless of operands.
- Result and flags are identical in both builds.

Test Plan:
- WIDTH=32, reset held 22 ns released; start ADD a=7 b=5 -> next edge result=12, flags=0000, done pulse 1 cycle, busy=0.
- SUB a=5 b=7 -> result=0xFFFFFFFE, flags N=1 Z=0 C=0 V=0; SUB a=7 b=7 -> result=0, flags 0110; ADD 0x7FFFFFFF+1 -> 0x80000000, flags 1001.
- MUL a=6 b=7 -> busy for 32 cycles, done after edge k+32, result=42, flags 0000. With SEQ_ALU_EARLY_TERM_EN: done after edge k+3.
- MUL a=0xFFFFFFFF b=2 -> result=0xFFFFFFFE, N=1. Pulse start with op=ADD mid-MUL -> ignored, MUL result unaffected.
- Assert reset at cycle 10 of a MUL -> all outputs 0 immediately, no done. After release, EOR a=0xF0 b=0xFF -> 0x0F; BIC a=0xFF b=0x0F -> 0xF0; op=111 -> result 0, flags 0100.
- start ADD raised in the same cycle done pulses for a prior MUL -> accepted; second done exactly one cycle later.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with an iterative shift-add multiplier.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request, sampled only while idle
//   op      000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL,
//           110 BIC (a & ~b), 111 reserved (result 0, Z set)
//   a, b    operands, sampled together with start
//   result  registered result, held until the next done
//   flags   {N,Z,C,V}, registered together with result
//   busy    high while a MUL is in progress
//   done    one-cycle pulse coincident with new result/flags
//
// Build option: define SEQ_ALU_EARLY_TERM_EN to finish a MUL as soon as the
// remaining multiplier bits are all zero (result and flags are unchanged).
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_BIC = 3'b110;

  typedef enum logic {IDLE, MULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNTW-1:0]  cnt;

  // Single-cycle datapath
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    // SUB is a + ~b + 1, so carry-out set means no borrow
    b_eff   = (op == OP_SUB) ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_EOR:  alu_res = a ^ b;
      OP_BIC:  alu_res = a & ~b;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step of the multiplier
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mcand_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic [CNTW-1:0]  cnt_nxt;
  logic             mul_fin;

  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    cnt_nxt    = cnt + CNTW'(1);
`ifdef SEQ_ALU_EARLY_TERM_EN
    mul_fin    = (cnt_nxt == CNTW'(WIDTH)) || (mplier_nxt == '0);
`else
    mul_fin    = (cnt_nxt == CNTW'(WIDTH));
`endif
  end

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MULT;
            end else begin
              result <= alu_res;
              flags  <= mk_flags(alu_res, alu_c, alu_v);
              done   <= 1'b1;
            end
          end
        end
        MULT: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt_nxt;
          if (mul_fin) begin
            result <= acc_nxt;
            flags  <= mk_flags(acc_nxt, 1'b0, 1'b0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32): directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op_r = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op_r),
    .a      (a),
    .b      (b),
    .result (result),
    .flags  (flags),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {N,Z,C,V, result} from plain integer arithmetic
  function automatic logic [35:0] model(input logic [2:0] op,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx;
    longint sy;
    longint s;
    logic [63:0] u;
    logic [31:0] r;
    logic c;
    logic v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        u = {32'd0, x} + {32'd0, y};
        r = u[31:0];
        c = u[32];
        s = sx + sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        u = {32'd0, x} * {32'd0, y};
        r = u[31:0];
      end
      3'd6: r = x & ~y;
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Cycles after the start edge until done is visible
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] y);
    int hb;
    if (op != 3'd5) return 0;
`ifdef SEQ_ALU_EARLY_TERM_EN
    hb = 0;
    for (int i = 0; i < 32; i++) if (y[i]) hb = i + 1;
    return (hb == 0) ? 1 : hb;
`else
    hb = W;
    return hb;
`endif
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge showing done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input bit noisy);
    logic [35:0] e;
    int cyc;
    int el;
    e = model(op, x, y);
    el = exp_lat(op, y);
    op_r = op;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start", busy, (op == 3'd5));
    cyc = 0;
    while (!done && cyc < 100) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        op_r = 3'($urandom);
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, el);
    check("result", result, e[31:0]);
    check("flags", flags, e[35:32]);
    check("busy_end", busy, 0);
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("done_drop", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    #12;
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'd5, 1'b0);
    check("add_flags", flags, 4'b0000);
    idle_check();
    run_op(3'd1, 32'd5, 32'd7, 1'b0);
    check("sub_res", result, 32'hFFFF_FFFE);
    check("sub_flags", flags, 4'b1000);
    idle_check();
    run_op(3'd1, 32'd7, 32'd7, 1'b0);
    check("sub_eq_flags", flags, 4'b0110);
    idle_check();
    run_op(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check("add_ovf_flags", flags, 4'b1001);
    idle_check();
    run_op(3'd5, 32'd6, 32'd7, 1'b0);
    check("mul_res", result, 32'd42);
    idle_check();
    run_op(3'd5, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("mul_neg_res", result, 32'hFFFF_FFFE);
    idle_check();

    // Reset in the middle of a multiply
    op_r = 3'd5; a = 32'd123; b = 32'h8000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("no_done_after_rst", dcount, 0);

    run_op(3'd4, 32'hF0, 32'hFF, 1'b0);
    check("eor_res", result, 32'h0F);
    run_op(3'd6, 32'hFF, 32'h0F, 1'b0);
    check("bic_res", result, 32'hF0);
    run_op(3'd7, 32'h1234, 32'h5678, 1'b0);
    check("rsv_flags", flags, 4'b0100);
    idle_check();

    // Back-to-back: ADD started in the cycle the MUL's done is high
    run_op(3'd5, 32'd11, 32'd13, 1'b0);
    run_op(3'd0, 32'd3, 32'd4, 1'b0);
    check("b2b_res", result, 32'd7);
    idle_check();

    for (int n = 0; n < 40; n++) begin
      logic [2:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (($urandom & 3) == 0) rb = rb & 32'h0000_00FF;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
